// File: rtl/vram_arb_pkg.sv
// vram_arb_pkg: shared owner tags, CPU FSM states and read latency for vram_arbiter
package vram_arb_pkg;
  localparam int RD_LAT = 1;
  typedef enum logic [1:0] {OWN_NONE, OWN_DSP, OWN_CPU} own_t;
  typedef enum logic [1:0] {C_IDLE, C_PEND, C_FLIGHT, C_ACK} cpu_st_t;
  typedef struct packed {
    own_t own;
    logic we;
  } tag_t;
endpackage

// File: rtl/vram_arbiter_if.sv
// vram_arbiter_if: display, CPU and RAM-side signals of the VRAM arbiter
interface vram_arbiter_if #(parameter int AW = 11, parameter int DW = 8);
  logic dsp_req;
  logic [AW-1:0] dsp_addr;
  logic [DW-1:0] dsp_data;
  logic dsp_valid;
  logic cpu_req;
  logic cpu_we;
  logic [AW-1:0] cpu_addr;
  logic [DW-1:0] cpu_wdata;
  logic [DW-1:0] cpu_rdata;
  logic cpu_ready;
  logic [AW-1:0] ram_addr;
  logic ram_we;
  logic [DW-1:0] ram_wdata;
  logic [DW-1:0] ram_rdata;
  modport master (
    output dsp_req, dsp_addr, cpu_req, cpu_we, cpu_addr, cpu_wdata, ram_rdata,
    input dsp_data, dsp_valid, cpu_rdata, cpu_ready, ram_addr, ram_we, ram_wdata
  );
  modport slave (
    input dsp_req, dsp_addr, cpu_req, cpu_we, cpu_addr, cpu_wdata, ram_rdata,
    output dsp_data, dsp_valid, cpu_rdata, cpu_ready, ram_addr, ram_we, ram_wdata
  );
endinterface

// File: rtl/vram_arb_wbuf.sv
// vram_arb_wbuf: one-entry posted CPU write buffer with address hit compare and drain on free slot
module vram_arb_wbuf #(parameter int AW = 11, parameter int DW = 8) (
  input  logic clk,
  input  logic rst,
  input  logic load,
  input  logic [AW-1:0] load_addr,
  input  logic [DW-1:0] load_data,
  input  logic slot_free,
  input  logic [AW-1:0] lookup,
  output logic valid,
  output logic [AW-1:0] addr,
  output logic [DW-1:0] data,
  output logic hit,
  output logic drain
);
  assign drain = valid && slot_free;
  assign hit = valid && lookup == addr;
  // load is only accepted while empty, so it never collides with a drain
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      valid <= 1'b0;
      addr <= '0;
      data <= '0;
    end else begin
      valid <= load || (valid && !slot_free);
      if (load) begin
        addr <= load_addr;
        data <= load_data;
      end
    end
endmodule

// File: rtl/vram_arbiter.sv
// vram_arbiter: single-port VRAM shared by display fetch (absolute priority) and CPU.
// Define VRAM_ARB_WBUF_EN to add a one-entry posted CPU write buffer.
module vram_arbiter
  import vram_arb_pkg::*;
#(parameter int AW = 11, parameter int DW = 8) (
  input logic clk,
  input logic rst,
  vram_arbiter_if.slave bus
);
  cpu_st_t st, st_nx;
  tag_t pipe [RD_LAT+1];
  logic cpu_idle, cpu_issue, fwd, wb_load, wb_valid, wb_hit, drain;
  logic [AW-1:0] wb_addr, ram_addr;
  logic [DW-1:0] wb_data, ram_wdata, dsp_data, cpu_rdata;
  logic ram_we, dsp_valid;
`ifdef VRAM_ARB_WBUF_EN
  localparam bit WBUF = 1'b1;
  vram_arb_wbuf #(.AW(AW), .DW(DW)) u_wbuf (
    .clk(clk), .rst(rst), .load(wb_load), .load_addr(bus.cpu_addr), .load_data(bus.cpu_wdata),
    .slot_free(!bus.dsp_req), .lookup(bus.cpu_addr), .valid(wb_valid), .addr(wb_addr),
    .data(wb_data), .hit(wb_hit), .drain(drain)
  );
`else
  localparam bit WBUF = 1'b0;
  assign {wb_valid, wb_hit, drain} = '0;
  assign wb_addr = '0;
  assign wb_data = '0;
`endif
  always_ff @(posedge clk or posedge rst)
    if (rst) st <= C_IDLE;
    else st <= st_nx;
  always_comb begin
    st_nx = st;
    case (st)
      C_IDLE, C_PEND: st_nx = !bus.cpu_req ? C_IDLE : (fwd || wb_load) ? C_ACK : cpu_issue ? C_FLIGHT : C_PEND;
      C_FLIGHT: st_nx = pipe[RD_LAT].own == OWN_CPU ? C_ACK : C_FLIGHT;
      default: st_nx = C_IDLE;
    endcase
  end
  // a pending buffer entry always drains before any direct CPU access
  always_comb begin
    cpu_idle = st == C_IDLE || st == C_PEND;
    fwd = cpu_idle && bus.cpu_req && !bus.cpu_we && wb_hit;
    wb_load = WBUF && cpu_idle && bus.cpu_req && bus.cpu_we && !wb_valid;
    cpu_issue = cpu_idle && bus.cpu_req && !fwd && !wb_load && !bus.dsp_req && !wb_valid;
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      ram_addr <= '0;
      ram_we <= 1'b0;
      ram_wdata <= '0;
      dsp_data <= '0;
      dsp_valid <= 1'b0;
      cpu_rdata <= '0;
      for (int i = 0; i <= RD_LAT; i++) pipe[i] <= '{OWN_NONE, 1'b0};
    end else begin
      if (bus.dsp_req) ram_addr <= bus.dsp_addr;
      else if (drain) begin
        ram_addr <= wb_addr;
        ram_wdata <= wb_data;
      end else if (cpu_issue) begin
        ram_addr <= bus.cpu_addr;
        ram_wdata <= bus.cpu_wdata;
      end
      ram_we <= !bus.dsp_req && (drain || (cpu_issue && bus.cpu_we));
      pipe[0] <= '{bus.dsp_req ? OWN_DSP : cpu_issue ? OWN_CPU : OWN_NONE, bus.cpu_we};
      for (int i = 1; i <= RD_LAT; i++) pipe[i] <= pipe[i-1];
      dsp_valid <= pipe[RD_LAT].own == OWN_DSP;
      if (pipe[RD_LAT].own == OWN_DSP) dsp_data <= bus.ram_rdata;
      if (fwd) cpu_rdata <= wb_data;
      else if (pipe[RD_LAT].own == OWN_CPU && !pipe[RD_LAT].we) cpu_rdata <= bus.ram_rdata;
    end
  assign bus.ram_addr = ram_addr;
  assign bus.ram_we = ram_we;
  assign bus.ram_wdata = ram_wdata;
  assign bus.dsp_data = dsp_data;
  assign bus.dsp_valid = dsp_valid;
  assign bus.cpu_rdata = cpu_rdata;
  assign bus.cpu_ready = st == C_ACK;
endmodule

// File: tb/tb_vram_arbiter.sv
// tb_vram_arbiter: directed self-checking bench for vram_arbiter with a behavioural synchronous RAM
module tb_vram_arbiter;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic bk_we = 1'b0;
  logic [10:0] bk_addr = '0;
  logic [7:0] bk_data = '0;
  logic [7:0] mem [0:2047];
  int checks = 0;
  int errors = 0;
  vram_arbiter_if #(.AW(11), .DW(8)) bus ();
  vram_arbiter #(.AW(11), .DW(8)) dut (.clk(clk), .rst(rst), .bus(bus));
  always #5 clk = ~clk;
  always @(posedge clk) begin
    if (bk_we) mem[bk_addr] <= bk_data;
    else if (bus.ram_we) mem[bus.ram_addr] <= bus.ram_wdata;
    bus.ram_rdata <= mem[bus.ram_addr];
  end
  initial begin
    #400000;
    $display("FAIL watchdog observed timeout expected finish");
    $fatal(1, "watchdog");
  end
  task automatic step();
    @(posedge clk);
    #1;
  endtask
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
    end
  endtask
  task automatic dsp_probe(input logic [10:0] a, input logic [7:0] d);
    bus.dsp_req = 1'b1;
    bus.dsp_addr = a;
    step();
    bus.dsp_req = 1'b0;
    chk("dsp_ram_addr", 32'(bus.ram_addr), 32'(a));
    chk("dsp_ram_we", 32'(bus.ram_we), 0);
    step();
    chk("dsp_early", 32'(bus.dsp_valid), 0);
    step();
    chk("dsp_valid", 32'(bus.dsp_valid), 1);
    chk("dsp_data", 32'(bus.dsp_data), 32'(d));
    step();
    chk("dsp_once", 32'(bus.dsp_valid), 0);
  endtask
  task automatic cpu_acc(input logic we, input logic [10:0] a, input logic [7:0] d,
                         output int lat, output int wecnt, output logic [7:0] rd);
    bus.cpu_req = 1'b1;
    bus.cpu_we = we;
    bus.cpu_addr = a;
    bus.cpu_wdata = d;
    lat = 0;
    wecnt = 0;
    do begin
      step();
      lat++;
      wecnt += int'(bus.ram_we);
    end while (!bus.cpu_ready && lat < 8);
    rd = bus.cpu_rdata;
    bus.cpu_req = 1'b0;
    step();
  endtask
  initial begin
    int lat, wecnt, s, acks;
    logic [7:0] rd;
    logic [2:0] dh;
    bus.dsp_req = 1'b0;
    bus.dsp_addr = '0;
    bus.cpu_req = 1'b0;
    bus.cpu_we = 1'b0;
    bus.cpu_addr = '0;
    bus.cpu_wdata = '0;
    bk_we = 1'b1;
    bk_addr = 11'h400;
    bk_data = 8'h5A;
    step();
    bk_we = 1'b0;
    step();
    chk("rst_dsp_valid", 32'(bus.dsp_valid), 0);
    chk("rst_dsp_data", 32'(bus.dsp_data), 0);
    chk("rst_cpu_ready", 32'(bus.cpu_ready), 0);
    chk("rst_cpu_rdata", 32'(bus.cpu_rdata), 0);
    chk("rst_ram_addr", 32'(bus.ram_addr), 0);
    chk("rst_ram_we", 32'(bus.ram_we), 0);
    chk("rst_ram_wdata", 32'(bus.ram_wdata), 0);
    rst = 1'b0;
    step();
    dsp_probe(11'h400, 8'h5A);
    cpu_acc(1'b1, 11'h010, 8'h3C, lat, wecnt, rd);
`ifdef VRAM_ARB_WBUF_EN
    chk("wr_lat", 32'(lat), 1);
    chk("wr_we_cycles", 32'(wecnt), 0);
`else
    chk("wr_lat", 32'(lat), 3);
    chk("wr_we_cycles", 32'(wecnt), 1);
`endif
    chk("wr_rdata_hold", 32'(rd), 0);
    cpu_acc(1'b0, 11'h010, 8'h00, lat, wecnt, rd);
    chk("rd_lat", 32'(lat), 3);
    chk("rd_data", 32'(rd), 'h3C);
    chk("rd_we_cycles", 32'(wecnt), 0);
    cpu_acc(1'b1, 11'h011, 8'h77, lat, wecnt, rd);
    chk("wr2_rdata_hold", 32'(rd), 'h3C);
    repeat (3) step();
    chk("wr2_mem", 32'(mem[11'h011]), 'h77);
    // display and CPU read in the same cycle
    bus.dsp_req = 1'b1;
    bus.dsp_addr = 11'h400;
    bus.cpu_req = 1'b1;
    bus.cpu_we = 1'b0;
    bus.cpu_addr = 11'h010;
    step();
    bus.dsp_req = 1'b0;
    chk("cf_dsp_first", 32'(bus.ram_addr), 'h400);
    step();
    chk("cf_cpu_second", 32'(bus.ram_addr), 'h010);
    step();
    chk("cf_dsp_valid", 32'(bus.dsp_valid), 1);
    chk("cf_dsp_data", 32'(bus.dsp_data), 'h5A);
    chk("cf_cpu_not_yet", 32'(bus.cpu_ready), 0);
    step();
    chk("cf_cpu_ready", 32'(bus.cpu_ready), 1);
    chk("cf_cpu_rdata", 32'(bus.cpu_rdata), 'h3C);
    bus.cpu_req = 1'b0;
    repeat (3) step();
    // display strobe every other cycle against back-to-back CPU reads
    dh = '0;
    acks = 0;
    s = 0;
    bus.cpu_addr = 11'h010;
    bus.cpu_we = 1'b0;
    for (int c = 0; c < 64; c++) begin
      chk("burst_dsp_valid", 32'(bus.dsp_valid), 32'(dh[2]));
      if (dh[2]) chk("burst_dsp_data", 32'(bus.dsp_data), 'h5A);
      if (bus.cpu_req && bus.cpu_ready) begin
        acks++;
        chk("burst_cpu_lat", 32'(c - s <= 4), 1);
        chk("burst_cpu_rdata", 32'(bus.cpu_rdata), 'h3C);
        bus.cpu_req = 1'b0;
      end else if (bus.cpu_req) chk("burst_cpu_wait", 32'(c - s < 4), 1);
      else begin
        bus.cpu_req = 1'b1;
        s = c;
      end
      bus.dsp_req = c % 2 == 0;
      bus.dsp_addr = 11'h400;
      dh = {dh[1:0], bus.dsp_req};
      step();
    end
    bus.dsp_req = 1'b0;
    bus.cpu_req = 1'b0;
    chk("burst_acks", 32'(acks >= 10), 1);
    repeat (6) step();
    // reset with a display read and a CPU read in flight
    bus.dsp_req = 1'b1;
    bus.dsp_addr = 11'h400;
    bus.cpu_req = 1'b1;
    bus.cpu_addr = 11'h010;
    step();
    bus.dsp_req = 1'b0;
    step();
    rst = 1'b1;
    bus.cpu_req = 1'b0;
    #1;
    chk("arst_ram_addr", 32'(bus.ram_addr), 0);
    chk("arst_ram_we", 32'(bus.ram_we), 0);
    chk("arst_cpu_rdata", 32'(bus.cpu_rdata), 0);
    chk("arst_dsp_data", 32'(bus.dsp_data), 0);
    step();
    step();
    rst = 1'b0;
    for (int c = 0; c < 6; c++) begin
      step();
      chk("post_rst_dsp_valid", 32'(bus.dsp_valid), 0);
      chk("post_rst_cpu_ready", 32'(bus.cpu_ready), 0);
    end
    dsp_probe(11'h400, 8'h5A);
    cpu_acc(1'b0, 11'h010, 8'h00, lat, wecnt, rd);
    chk("post_rst_rd_lat", 32'(lat), 3);
    chk("post_rst_rd_data", 32'(rd), 'h3C);
`ifdef VRAM_ARB_WBUF_EN
    bus.cpu_req = 1'b1;
    bus.cpu_we = 1'b1;
    bus.cpu_addr = 11'h020;
    bus.cpu_wdata = 8'hA5;
    step();
    chk("wb_wr_ready", 32'(bus.cpu_ready), 1);
    bus.cpu_req = 1'b0;
    bus.dsp_req = 1'b1;
    bus.dsp_addr = 11'h400;
    step();
    bus.dsp_req = 1'b0;
    chk("wb_dsp_slot", 32'(bus.ram_we), 0);
    bus.cpu_req = 1'b1;
    bus.cpu_we = 1'b0;
    bus.cpu_addr = 11'h020;
    step();
    chk("wb_rd_ready", 32'(bus.cpu_ready), 1);
    chk("wb_rd_fwd", 32'(bus.cpu_rdata), 'hA5);
    chk("wb_drain_we", 32'(bus.ram_we), 1);
    chk("wb_drain_addr", 32'(bus.ram_addr), 'h020);
    bus.cpu_req = 1'b0;
    step();
    chk("wb_mem", 32'(mem[11'h020]), 'hA5);
    chk("wb_dsp_valid", 32'(bus.dsp_valid), 1);
    repeat (3) step();
`endif
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/vram_arbiter.md
# vram_arbiter

Shares one synchronous single-port video RAM (e.g. H1/L1 VRAM, 2^AW x DW) between the display fetch path (tile-code reads feeding the L2 latch) and the 6502 bus. Display reads have absolute priority and fixed latency; CPU accesses wait for a free slot and are acknowledged with a one-cycle `cpu_ready` pulse that gates the CPU enable. The block sits between the address decode (`nVRAM`) and the RAM primitive, replacing direct dual-port access.

## Interface
- `AW`, 11, RAM address width
- `DW`, 8, RAM data width
- `clk` in 1 system clock; all logic rising-edge
- `rst` in 1 reset, asynchronous, active-high
- `dsp_req` in 1 single-cycle display fetch strobe; spacing >= 2 cycles guaranteed by timing chain
- `dsp_addr` in AW display address (VA), valid with `dsp_req`
- `dsp_data` out DW fetched display byte
- `dsp_valid` out 1 one-cycle strobe, `dsp_data` valid
- `cpu_req` in 1 CPU access request (decoded `!nVRAM` qualified by cpu_clken), held until `cpu_ready`
- `cpu_we` in 1 1 = write
- `cpu_addr` in AW CPU address A[AW-1:0]
- `cpu_wdata` in DW write data
- `cpu_rdata` out DW read data, valid with `cpu_ready`
- `cpu_ready` out 1 one-cycle acknowledge
- `ram_addr` out AW RAM address (registered)
- `ram_we` out 1 RAM write enable (registered)
- `ram_wdata` out DW RAM write data (registered)
- `ram_rdata` in DW RAM read data, valid one cycle after address presented

## Operation
- One RAM slot per cycle. Arbiter samples requests in cycle t, drives `ram_*` registers for cycle t+1.
- Priority: `dsp_req` always wins the slot; CPU granted only when `dsp_req`=0.
- Owner tag (NONE/DSP/CPU) travels with each issued access through a 2-stage pipeline; returned data routed by tag, so display and CPU accesses may be in flight simultaneously.
- CPU FSM: C_IDLE -> (cpu_req & slot free) C_FLIGHT; C_IDLE -> (cpu_req & dsp_req) C_PEND; C_PEND -> (slot free) C_FLIGHT; C_FLIGHT -> C_ACK after data return; C_ACK (`cpu_ready`=1) -> C_IDLE. A CPU request is granted at most once; `cpu_req` is ignored in C_FLIGHT/C_ACK.
- `cpu_req` dropped after grant: access still completes, `cpu_ready` still pulses. `cpu_req` dropped in C_PEND: return to C_IDLE, no access.
- Writes: `ram_we`=1 for exactly the issue cycle; `cpu_rdata` holds previous value on write acknowledge.
- Non-granted cycles: `ram_we`=0, `ram_addr`/`ram_wdata` hold.
- Reset: all outputs 0, FSM C_IDLE, pipeline tags NONE; in-flight accesses discarded, no strobes after reset release until new requests.

## Timing
- Display: `dsp_req` cycle t -> `ram_addr`=`dsp_addr` t+1 -> `ram_rdata` t+2 -> `dsp_valid`/`dsp_data` t+3. Fixed 3 cycles, never delayed.
- CPU, no conflict: `cpu_req` t -> issue t+1 -> `cpu_ready` t+3 (read and write).
- CPU, conflict: +1 cycle per display slot taken; with guaranteed display spacing, worst case `cpu_ready` at t+4.
- Minimum CPU request-to-request: new access sampled no earlier than cycle after `cpu_ready`.

## Configuration
- `VRAM_ARB_WBUF_EN` defined: 1-entry posted write buffer. CPU write with buffer empty -> `cpu_ready` at t+1, data buffered, drained in next free slot (display still wins). CPU read hitting buffered address -> data forwarded from buffer, `cpu_ready` at t+1. Write with buffer full -> C_PEND until drained. Read miss with buffer full -> buffer drains first, then read.
- Undefined: no buffer; all writes follow normal CPU path (t+3).

## Structure
- Package `vram_arb_pkg`: owner tag enum (OWN_NONE, OWN_DSP, OWN_CPU), CPU FSM state enum, localparam `RD_LAT`=1.
- Sub-module `vram_arb_wbuf` (buffer valid/addr/data, hit compare, drain handshake), instantiated only under `VRAM_ARB_WBUF_EN`.

## Test plan
- Reset, then `dsp_req` with `dsp_addr`=0x400, RAM[0x400]=0x5A -> `dsp_valid`=1 with `dsp_data`=0x5A exactly 3 cycles later; all outputs 0 during reset.
- CPU write 0x3C to 0x010, then read 0x010, no display traffic -> `ram_we` one cycle, each `cpu_ready` at t+3, read returns 0x3C.
- `dsp_req` and CPU read same cycle -> display issued first, CPU issued next cycle, `cpu_ready` at t+4; both data values correct.
- Display strobes every 2 cycles for 64 cycles with continuous CPU reads -> every `dsp_valid` exactly 3 cycles after strobe; every CPU access acked within 4 cycles.
- Assert `rst` while CPU read and display read in flight -> no `dsp_valid`/`cpu_ready` after release; next requests behave as from reset.
- With `VRAM_ARB_WBUF_EN`: write 0xA5 to 0x020 during display burst -> `cpu_ready` at t+1; immediate read 0x020 returns 0xA5 at t+1; RAM[0x020]=0xA5 after first free slot.
